mem_to_com_fsm: RTL and testbench
=================================

Name: mem_to_com_fsm

Overview:
Read-back responder for the UART command path. It takes a read request (start address and word count), fetches words from the frame memory read port and transmits each word as lowercase ASCII hex to the UART transmitter, one byte per handshake. Words are separated by a space and each response ends with CR LF. It sits between the frame memory read port and the UART TX, and is triggered by the command parser's read state or any other requester.

Parameters:
ADDR_WIDTH, 17, memory address width
DATA_WIDTH, 12, memory word width; hex digits per word NDIG = ceil(DATA_WIDTH/4) = 3
DEPTH, 76_800, memory depth; the address wraps at DEPTH-1
READ_LATENCY, 1, cycles from o_addr_rd change to valid i_mem_data (range 1..3)
LEN_WIDTH, 8, width of the word-count input

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_enable  in  1  clock enable; while low all state, counters and outputs hold
i_start  in  1  request pulse; sampled only in IDLE
i_addr  in  ADDR_WIDTH  start address, latched on accepted i_start
i_len  in  LEN_WIDTH  number of words to send, latched on accepted i_start
o_addr_rd  out  ADDR_WIDTH  memory read address
i_mem_data  in  DATA_WIDTH  memory read data
o_TX_DV  out  1  one-cycle pulse: o_TX_Byte is valid, start transmission
o_TX_Byte  out  8  byte to transmit; held stable until the matching i_TX_Done
i_TX_Done  in  1  one-cycle pulse from the UART TX when the byte is finished
o_busy  out  1  high from accepted i_start until o_done
o_done  out  1  one-cycle pulse after the final LF's i_TX_Done
o_state  out  4  current state, for debug LEDs

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high and overrides i_enable.
- Reset values: state IDLE; o_TX_DV=0, o_TX_Byte=0, o_addr_rd=0, o_busy=0, o_done=0.
- States (4-bit encoding): IDLE=0, RD_ADDR=1, RD_WAIT=2, LATCH=3, SEND=4, WAIT_TX=5, NEXT=6, SEND_CR=7, SEND_LF=8.
- IDLE:
  - on i_start, latch i_addr into the address counter and i_len into the word counter; set o_busy=1.
  - go to RD_ADDR if i_len != 0, else go to SEND_CR.
- RD_ADDR: drive o_addr_rd = address counter; load the wait counter with READ_LATENCY; go to RD_WAIT.
- RD_WAIT: decrement the wait counter; on reaching 0 go to LATCH.
- LATCH:
  - capture i_mem_data zero-extended to 4*NDIG bits into the shift register; digit index = NDIG-1.
  - go to SEND.
- SEND: o_TX_Byte = ASCII of the nibble at the digit index; o_TX_DV=1 for exactly one cycle; go to WAIT_TX.
- WAIT_TX: wait for i_TX_Done. Byte sequencing:
  - digit index > 0: decrement the index; go to SEND.
  - digit index = 0, more words pending: send a space byte (0x20), then go to NEXT.
  - digit index = 0, last word: go to SEND_CR.
- NEXT:
  - address counter becomes 0 if it equals DEPTH-1, else address + 1.
  - decrement the word counter; go to RD_ADDR.
- SEND_CR / SEND_LF:
  - send 0x0D and then 0x0A, each with the same DV pulse and Done wait.
  - after the LF's i_TX_Done: o_done=1 for one cycle, o_busy=0, go to IDLE.
- Nibble encoding: 0-9 → 0x30-0x39; a-f → 0x61-0x66. Lowercase matches the command parser's input alphabet.
- Byte timing:
  - the next o_TX_DV is issued exactly one cycle after i_TX_Done is seen, so there are at least 2 cycles between consecutive DV pulses.
  - i_TX_Done outside WAIT_TX or the CR/LF waits is ignored.
- Boundary conditions:
  - i_start while busy: ignored; the latched address and length are unchanged.
  - i_start and i_TX_Done in the same cycle: only the active state's rule applies.
  - i_len = 0: only CR LF is sent; no memory read is issued.
  - i_len = 2^LEN_WIDTH-1: all words are sent; the counter never underflows.
  - Start address >= DEPTH: clamp to 0.
  - i_enable low: the FSM holds; an o_TX_DV pulse is never stretched, since DV is asserted only in enabled cycles. An i_TX_Done pulse that arrives while disabled is captured in a pending flag and consumed when enable returns.
  - rst mid-transfer: immediately IDLE with outputs at reset values. A byte already in the UART completes; its Done is ignored.

Decomposition:
- Shared package com_pkg:
  - state encodings;
  - ASCII constants: ASCII_SP=0x20, ASCII_CR=0x0D, ASCII_LF=0x0A, ASCII_0=0x30, ASCII_A_LC=0x61;
  - NDIG function;
  - the command bytes 'p', 'r', 'P' already used by the command parser.
- One sub-module, nibble_to_ascii: a 4-bit to 8-bit lowercase hex encoder, so the command parser's decode side can share the constant set.

Test Plan:
- mem[5]=0xa3f; start addr=5, len=1 → bytes 0x61 0x33 0x66 0x0D 0x0A; one o_done pulse; o_busy low afterwards.
- mem[76799]=0x001, mem[0]=0xfff; addr=76799, len=2 → "001 fff\r\n"; o_addr_rd sequence 76799 then 0.
- len=0 → only 0x0D 0x0A; o_addr_rd is never changed.
- i_start pulsed again during the second digit → ignored; output is unchanged; only one o_done.
- READ_LATENCY=2, model UART Done 10 cycles after each DV → every captured word equals the memory content; DV never asserts before the previous Done.
- rst asserted during WAIT_TX of the middle digit → next cycle state=0, o_TX_DV=0, o_busy=0. A subsequent start (addr=5, len=1) again sends the full 5-byte response.

Source files
------------

// File: rtl/com_pkg.sv
// ============================================================================
// com_pkg
// Shared definitions for the UART command path: responder state encodings,
// ASCII constants for hex/CR/LF framing, the command bytes already used by
// the command parser, and a helper giving the number of hex digits per word.
// ============================================================================
package com_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RD_ADDR = 4'd1,
        ST_RD_WAIT = 4'd2,
        ST_LATCH   = 4'd3,
        ST_SEND    = 4'd4,
        ST_WAIT_TX = 4'd5,
        ST_NEXT    = 4'd6,
        ST_SEND_CR = 4'd7,
        ST_SEND_LF = 4'd8
    } state_t;

    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_A_LC = 8'h61;

    // Command bytes understood by the command parser
    localparam logic [7:0] CMD_P_LC   = 8'h70;  // 'p'
    localparam logic [7:0] CMD_R_LC   = 8'h72;  // 'r'
    localparam logic [7:0] CMD_P_UC   = 8'h50;  // 'P'

    // Hex digits needed to print a word of the given width
    function automatic int unsigned ndig(input int unsigned width);
        return (width + 32'd3) / 32'd4;
    endfunction

endpackage

// File: rtl/nibble_to_ascii.sv
// ============================================================================
// nibble_to_ascii
// Combinational 4-bit to lowercase ASCII hex encoder (0-9 -> '0'-'9',
// a-f -> 'a'-'f'), matching the alphabet the command parser accepts.
// Ports:
//   i_nibble  in  4  value to encode
//   o_ascii   out 8  ASCII character
// ============================================================================
module nibble_to_ascii
    import com_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii
);

    // Select the digit or letter range and offset into it
    always_comb begin
        if (i_nibble < 4'd10) begin
            o_ascii = ASCII_0 + {4'd0, i_nibble};
        end else begin
            o_ascii = ASCII_A_LC + {4'd0, i_nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/mem_to_com_fsm.sv
// ============================================================================
// mem_to_com_fsm
// Read-back responder: on a request (start address, word count) it reads
// words from the frame memory and sends each as lowercase hex over the UART
// TX, one byte per DV/Done handshake, words separated by a space, response
// terminated by CR LF.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   i_enable         clock enable (pulse outputs are never stretched)
//   i_start          request pulse, sampled only in IDLE
//   i_addr, i_len    start address and word count
//   o_addr_rd        memory read address
//   i_mem_data       memory read data, valid READ_LATENCY cycles after address
//   o_TX_DV          one-cycle byte-valid strobe to the UART TX
//   o_TX_Byte        byte to send, stable until the matching i_TX_Done
//   i_TX_Done        one-cycle byte-finished pulse from the UART TX
//   o_busy, o_done   request in progress / one-cycle completion pulse
//   o_state          current state for debug LEDs
// ============================================================================
module mem_to_com_fsm
    import com_pkg::*;
#(
    parameter int ADDR_WIDTH   = 17,
    parameter int DATA_WIDTH   = 12,
    parameter int DEPTH        = 76_800,
    parameter int READ_LATENCY = 1,
    parameter int LEN_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [LEN_WIDTH-1:0]  i_len,
    output logic [ADDR_WIDTH-1:0] o_addr_rd,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic                  o_TX_DV,
    output logic [7:0]            o_TX_Byte,
    input  logic                  i_TX_Done,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [3:0]            o_state
);

    localparam int NDIG  = int'(ndig(DATA_WIDTH));
    localparam int SHW   = 4 * NDIG;
    localparam int DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [DIG_W-1:0]      TOP_DIG   = DIG_W'(NDIG - 1);
    localparam logic [DIG_W-1:0]      DIG_ONE   = {{(DIG_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    // One extra bit so DEPTH itself is representable in the clamp compare
    localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [1:0]            LAT_LOAD  = 2'(READ_LATENCY);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [1:0]            r_wait;
    logic [SHW-1:0]        r_shift;
    logic [DIG_W-1:0]      r_dig;
    logic                  r_sp;        // space byte in flight, NEXT follows its Done
    logic                  r_sent;      // CR/LF byte already strobed, now waiting Done
    logic                  r_done_pend; // Done that arrived while disabled
    logic [ADDR_WIDTH-1:0] r_addr_rd;
    logic                  r_tx_dv;
    logic [7:0]            r_tx_byte;
    logic                  r_busy;
    logic                  r_done;

    logic [3:0]            w_nibble;
    logic [7:0]            w_ascii;
    logic                  w_tx_done;

    assign w_nibble  = 4'(r_shift >> {r_dig, 2'b00});
    assign w_tx_done = i_TX_Done | r_done_pend;

    nibble_to_ascii u_enc (
        .i_nibble (w_nibble),
        .o_ascii  (w_ascii)
    );

    // Responder FSM with all counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= ADDR_ZERO;
            r_cnt       <= LEN_ZERO;
            r_wait      <= 2'd0;
            r_shift     <= {SHW{1'b0}};
            r_dig       <= {DIG_W{1'b0}};
            r_sp        <= 1'b0;
            r_sent      <= 1'b0;
            r_done_pend <= 1'b0;
            r_addr_rd   <= ADDR_ZERO;
            r_tx_dv     <= 1'b0;
            r_tx_byte   <= 8'h00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (!i_enable) begin
            // Hold everything; drop pulses so they are never stretched and
            // remember a Done so the handshake is not lost.
            r_tx_dv     <= 1'b0;
            r_done      <= 1'b0;
            r_done_pend <= r_done_pend | i_TX_Done;
        end else begin
            r_tx_dv     <= 1'b0;
            r_done      <= 1'b0;
            r_done_pend <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_addr <= ({1'b0, i_addr} >= DEPTH_X) ? ADDR_ZERO : i_addr;
                        r_cnt  <= i_len;
                        r_busy <= 1'b1;
                        r_sent <= 1'b0;
                        r_sp   <= 1'b0;
                        r_state <= (i_len != LEN_ZERO) ? ST_RD_ADDR : ST_SEND_CR;
                    end
                end
                ST_RD_ADDR: begin
                    r_addr_rd <= r_addr;
                    r_wait    <= LAT_LOAD;
                    r_state   <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    r_wait <= r_wait - 2'd1;
                    if (r_wait <= 2'd1) begin
                        r_state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    r_shift <= SHW'(i_mem_data);
                    r_dig   <= TOP_DIG;
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    r_tx_byte <= w_ascii;
                    r_tx_dv   <= 1'b1;
                    r_state   <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (w_tx_done) begin
                        if (r_sp) begin
                            r_sp    <= 1'b0;
                            r_state <= ST_NEXT;
                        end else if (r_dig != {DIG_W{1'b0}}) begin
                            r_dig   <= r_dig - DIG_ONE;
                            r_state <= ST_SEND;
                        end else if (r_cnt > LEN_ONE) begin
                            // Separator goes out straight from here; its Done
                            // is awaited in this same state.
                            r_tx_byte <= ASCII_SP;
                            r_tx_dv   <= 1'b1;
                            r_sp      <= 1'b1;
                        end else begin
                            r_sent  <= 1'b0;
                            r_state <= ST_SEND_CR;
                        end
                    end
                end
                ST_NEXT: begin
                    r_addr  <= (r_addr == LAST_ADDR) ? ADDR_ZERO : r_addr + ADDR_ONE;
                    r_cnt   <= r_cnt - LEN_ONE;
                    r_state <= ST_RD_ADDR;
                end
                ST_SEND_CR: begin
                    if (!r_sent) begin
                        r_tx_byte <= ASCII_CR;
                        r_tx_dv   <= 1'b1;
                        r_sent    <= 1'b1;
                    end else if (w_tx_done) begin
                        r_sent  <= 1'b0;
                        r_state <= ST_SEND_LF;
                    end
                end
                ST_SEND_LF: begin
                    if (!r_sent) begin
                        r_tx_byte <= ASCII_LF;
                        r_tx_dv   <= 1'b1;
                        r_sent    <= 1'b1;
                    end else if (w_tx_done) begin
                        r_sent  <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_sent  <= 1'b0;
                    r_sp    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_addr_rd = r_addr_rd;
    assign o_TX_DV   = r_tx_dv;
    assign o_TX_Byte = r_tx_byte;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_state   = r_state;

endmodule

// File: tb/tb_mem_to_com_fsm.sv
// ============================================================================
// tb_mem_to_com_fsm
// Directed bench: a two-stage memory model (READ_LATENCY=2) and a UART model
// that returns Done 10 cycles after each DV. Expected byte streams are
// hand-written hex strings.
// ============================================================================
module tb_mem_to_com_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable;
    logic        i_start;
    logic [16:0] i_addr;
    logic [7:0]  i_len;
    logic [16:0] o_addr_rd;
    logic [11:0] i_mem_data;
    logic        o_TX_DV;
    logic [7:0]  o_TX_Byte;
    logic        i_TX_Done;
    logic        o_busy;
    logic        o_done;
    logic [3:0]  o_state;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  rx_q[$];
    logic [16:0] addr_q[$];
    int          done_cnt;
    int          tx_cnt;
    logic [11:0] m1, m2;
    logic [16:0] last_addr;

    always #5 clk = ~clk;

    mem_to_com_fsm #(
        .ADDR_WIDTH   (17),
        .DATA_WIDTH   (12),
        .DEPTH        (76_800),
        .READ_LATENCY (2),
        .LEN_WIDTH    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_enable   (i_enable),
        .i_start    (i_start),
        .i_addr     (i_addr),
        .i_len      (i_len),
        .o_addr_rd  (o_addr_rd),
        .i_mem_data (i_mem_data),
        .o_TX_DV    (o_TX_DV),
        .o_TX_Byte  (o_TX_Byte),
        .i_TX_Done  (i_TX_Done),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_state    (o_state)
    );

    function automatic logic [11:0] mem_val(input logic [16:0] a);
        case (a)
            17'd5:     return 12'ha3f;
            17'd76799: return 12'h001;
            17'd0:     return 12'hfff;
            17'd10:    return 12'h123;
            17'd11:    return 12'h4b0;
            17'd12:    return 12'he09;
            default:   return a[11:0];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] byte_at(input int idx);
        if (idx < rx_q.size()) return {24'd0, rx_q[idx]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic cmp_at(input string tag, input int base, input string s);
        for (int i = 0; i < s.len(); i++) begin
            chk($sformatf("%s_b%0d", tag, base + i), byte_at(base + i), {24'd0, s[i]});
        end
    endtask

    task automatic cmp_body(input string tag, input string body);
        chk({tag, "_len"}, rx_q.size(), body.len() + 2);
        cmp_at(tag, 0, body);
        chk({tag, "_cr"}, byte_at(body.len()), 32'h0D);
        chk({tag, "_lf"}, byte_at(body.len() + 1), 32'h0A);
    endtask

    // mode 0: plain; 1: re-pulse i_start at the second digit; 2: disable mid-byte
    task automatic do_req(input string tag, input logic [16:0] a, input logic [7:0] n, input int mode);
        bit acted = 1'b0;
        rx_q.delete();
        addr_q.delete();
        done_cnt = 0;
        @(negedge clk);
        i_addr  = a;
        i_len   = n;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk({tag, "_busy_on"}, o_busy, 1);
        for (int c = 0; c < 40000 && done_cnt == 0; c++) begin
            @(negedge clk);
            if (mode == 1 && !acted && rx_q.size() == 2) begin
                acted   = 1'b1;
                i_addr  = 17'd0;
                i_len   = 8'd3;
                i_start = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            if (mode == 2 && !acted && rx_q.size() == 1) begin
                acted    = 1'b1;
                i_enable = 1'b0;
                repeat (15) @(negedge clk);
                chk({tag, "_en_hold"}, o_state, 4'd5);
                chk({tag, "_en_dv"}, o_TX_DV, 0);
                i_enable = 1'b1;
            end
        end
        i_start = 1'b0;
        chk({tag, "_done_seen"}, (done_cnt != 0), 1);
        repeat (5) @(negedge clk);
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_busy_off"}, o_busy, 0);
    endtask

    // Memory pipeline, UART TX model and output monitors, updated just after each edge
    initial begin
        m1 = 12'd0; m2 = 12'd0; i_mem_data = 12'd0;
        i_TX_Done = 1'b0; tx_cnt = 0; done_cnt = 0; last_addr = 17'd0;
        forever begin
            @(posedge clk);
            #1;
            i_mem_data = m2;
            m2 = m1;
            m1 = mem_val(o_addr_rd);
            if (o_addr_rd !== last_addr) begin
                addr_q.push_back(o_addr_rd);
                last_addr = o_addr_rd;
            end
            if (o_done) done_cnt++;
            i_TX_Done = 1'b0;
            if (o_TX_DV) begin
                chk("dv_gap", tx_cnt, 0);
                rx_q.push_back(o_TX_Byte);
                tx_cnt = 10;
            end else if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) i_TX_Done = 1'b1;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_enable = 1'b1; i_start = 1'b0; i_addr = 17'd0; i_len = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_state", o_state, 4'd0);
        chk("rst_dv",    o_TX_DV, 0);
        chk("rst_byte",  o_TX_Byte, 8'h00);
        chk("rst_addr",  o_addr_rd, 17'd0);
        chk("rst_busy",  o_busy, 0);
        chk("rst_done",  o_done, 0);
        rst = 1'b0;

        do_req("t1", 17'd5, 8'd1, 0);
        cmp_body("t1", "a3f");
        chk("t1_naddr", addr_q.size(), 1);
        chk("t1_addr0", (addr_q.size() > 0) ? addr_q[0] : 17'h1ffff, 17'd5);

        do_req("t2", 17'd76799, 8'd2, 0);
        cmp_body("t2", "001 fff");
        chk("t2_naddr", addr_q.size(), 2);
        chk("t2_addr0", (addr_q.size() > 0) ? addr_q[0] : 17'h1ffff, 17'd76799);
        chk("t2_addr1", (addr_q.size() > 1) ? addr_q[1] : 17'h1ffff, 17'd0);

        do_req("t3", 17'd10, 8'd0, 0);
        cmp_body("t3", "");
        chk("t3_naddr", addr_q.size(), 0);

        do_req("t4", 17'd5, 8'd1, 1);
        cmp_body("t4", "a3f");

        do_req("t5", 17'd80000, 8'd1, 0);
        cmp_body("t5", "fff");
        chk("t5_addr0", (addr_q.size() > 0) ? addr_q[0] : 17'h1ffff, 17'd0);

        do_req("t6", 17'd10, 8'd3, 0);
        cmp_body("t6", "123 4b0 e09");

        do_req("t7", 17'd11, 8'd1, 2);
        cmp_body("t7", "4b0");

        // Reset during the middle digit's wait
        rx_q.delete();
        @(negedge clk);
        i_addr = 17'd5; i_len = 8'd1; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int c = 0; c < 2000 && rx_q.size() < 2; c++) @(negedge clk);
        chk("t8_reach", rx_q.size(), 2);
        repeat (3) @(negedge clk);
        chk("t8_pre_state", o_state, 4'd5);
        rst = 1'b1;
        @(negedge clk);
        chk("t8_state", o_state, 4'd0);
        chk("t8_dv",    o_TX_DV, 0);
        chk("t8_busy",  o_busy, 0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        do_req("t8b", 17'd5, 8'd1, 0);
        cmp_body("t8b", "a3f");

        // Full-length request crossing the address wrap
        do_req("t9", 17'd76700, 8'd255, 0);
        chk("t9_len", rx_q.size(), 1021);
        cmp_at("t9_first", 0, "b9c ");
        cmp_at("t9_wrap", 396, "001 fff");
        cmp_at("t9_last", 1016, "09a");
        chk("t9_cr", byte_at(1019), 32'h0D);
        chk("t9_lf", byte_at(1020), 32'h0A);
        chk("t9_end_addr", o_addr_rd, 17'd154);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
